// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed BCD seven-segment scanner with frame-synchronous reload
module seg7_scan_driver #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] digits_in,
    input  logic [7:0]  blank_in,
    output logic        ready,
    output logic [6:0]  seg,
    output logic [7:0]  anodes,
    output logic        frame_done
);
    localparam int CW = $clog2(PRESCALE);
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   pend_digit, disp_digit;
    logic [7:0]    pend_blank, disp_blank;
    logic          tick, boundary;
    logic [3:0]    nib;
    logic [6:0]    dec;
    assign tick     = cnt == CW'(PRESCALE - 1);
    assign boundary = tick && idx == 3'd7;
    assign nib      = disp_digit[4*idx +: 4];
    // active-low {g..a} pattern for the nibble of the current slot; 10-15 show a dash
    always_comb begin
        dec = 7'b0111111;
        case (nib)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end
    // slot timing: prescaler, digit index and end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            idx        <= tick ? idx + 3'd1 : idx;
            frame_done <= boundary;
        end
    end
    // load handshake; display registers only swap at a frame boundary so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready      <= 1'b1;
            pend_digit <= '0;
            pend_blank <= 8'hFF;
            disp_digit <= '0;
            disp_blank <= 8'hFF;
        end else if (boundary && !ready) begin
            disp_digit <= pend_digit;
            disp_blank <= pend_blank;
            ready      <= 1'b1;
        end else if (load && ready) begin
            pend_digit <= digits_in;
            pend_blank <= blank_in;
            ready      <= 1'b0;
        end
    end
    // registered drive; the last cycle of each slot is dark to stop ghosting into the next digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodes <= 8'hFF;
            seg    <= 7'h7F;
        end else begin
            anodes <= (tick || disp_blank[idx]) ? 8'hFF : ~(8'd1 << idx);
            seg    <= (tick || disp_blank[idx]) ? 7'h7F : dec;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench against a cycle-count reference of the scanner
module tb_seg7_scan_driver;
    localparam int P = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] digits_in;
    logic [7:0]  blank_in;
    logic        ready;
    logic [6:0]  seg;
    logic [7:0]  anodes;
    logic        frame_done;
    int compared = 0;
    int mism = 0;
    logic [16:0] q[$];
    logic seen_fe = 1'b0, seen_fd = 1'b0, seen_dash = 1'b0;
    logic [6:0] dtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    seg7_scan_driver #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
        .ready(ready), .seg(seg), .anodes(anodes), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // reference: position in the scan follows from edges counted since reset release
    initial begin
        int n, c, i;
        logic busy, bd;
        logic [31:0] pd, dd;
        logic [7:0] pb, db, ea;
        logic [6:0] es;
        n = 0; busy = 0; pd = 0; dd = 0; pb = 8'hFF; db = 8'hFF;
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; busy = 0; pd = 0; dd = 0; pb = 8'hFF; db = 8'hFF;
                q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0});
            end else begin
                c  = n % P;
                i  = (n / P) % 8;
                bd = (c == P - 1) && (i == 7);
                ea = (c == P - 1 || db[i]) ? 8'hFF : ~(8'd1 << i);
                es = (c == P - 1 || db[i]) ? 7'h7F : dtab[dd[4*i +: 4]];
                if (bd && busy) begin
                    dd = pd; db = pb; busy = 0;
                end else if (load && !busy) begin
                    pd = digits_in; pb = blank_in; busy = 1;
                end
                q.push_back({ea, es, !busy, bd});
                n++;
            end
        end
    end

    // monitor: the outputs are presented every cycle, checked mid-cycle
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if ({anodes, seg, ready, frame_done} !== e) begin
                    mism++;
                    $display("FAIL scan t=%0t got an=%h seg=%b rdy=%b fd=%b want an=%h seg=%b rdy=%b fd=%b",
                             $time, anodes, seg, ready, frame_done, e[16:9], e[8:2], e[1], e[0]);
                end
                if (anodes == 8'hFE && seg == 7'b1000000) seen_fe = 1'b1;
                if (anodes == 8'hFD && seg == 7'b1111001) seen_fd = 1'b1;
                if (anodes == 8'hDF && seg == 7'b0111111) seen_dash = 1'b1;
            end
        end
    end

    task automatic check_rst(input string name);
        compared++;
        if ({anodes, seg, ready, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            mism++;
            $display("FAIL %s got an=%h seg=%b rdy=%b fd=%b want an=ff seg=1111111 rdy=1 fd=0",
                     name, anodes, seg, ready, frame_done);
        end
    endtask

    task automatic check_flag(input string name, input logic v);
        compared++;
        if (v !== 1'b1) begin
            mism++;
            $display("FAIL %s got %b want 1", name, v);
        end
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 300 && !ready; k++) @(negedge clk);
        if (!ready) begin
            compared++; mism++;
            $display("FAIL ready_timeout got rdy=0 want 1 within 300 cycles");
        end
    endtask

    task automatic wait_fd();
        int k;
        for (k = 0; k < 300 && !frame_done; k++) @(negedge clk);
        if (!frame_done) begin
            compared++; mism++;
            $display("FAIL fd_timeout got fd=0 want 1 within 300 cycles");
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b);
        wait_ready();
        digits_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int c;
        logic done;
        rst = 1'b1; load = 1'b0; digits_in = '0; blank_in = '0;
        #1 check_rst("rst_async_init");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_load(32'h76543210, 8'h00);
        repeat (70) @(negedge clk);
        d = $urandom; d[23:20] = 4'hC;
        do_load(d, 8'h00);
        repeat (70) @(negedge clk);
        do_load($urandom, 8'h08);
        repeat (70) @(negedge clk);
        do_load(32'h99887766, 8'h00);
        digits_in = 32'h11111111; blank_in = 8'hF0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (70) @(negedge clk);
        wait_ready();
        wait_fd();
        repeat (31) @(negedge clk);
        digits_in = $urandom; blank_in = 8'(($urandom_range(0, 255)) & 8'h33); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (70) @(negedge clk);
        for (int r = 0; r < 10; r++) begin
            do_load($urandom, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
            repeat ($urandom_range(1, 80)) @(negedge clk);
        end
        do_load(32'h88888888, 8'h00);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_rst("rst_async_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = 0; done = 1'b0;
        while (!done && c < 100) begin
            @(posedge clk);
            c++;
            #1 if (frame_done) done = 1'b1;
        end
        compared++;
        if (c != 32) begin
            mism++;
            $display("FAIL first_fd_after_rst got %0d cycles want 32", c);
        end
        repeat (70) @(negedge clk);
        check_flag("saw_fe_zero", seen_fe);
        check_flag("saw_fd_one", seen_fd);
        check_flag("saw_df_dash", seen_dash);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
